// File: rtl/ssd_pkg.sv
// Shared constants and hex-to-segment table for the seven-segment scan driver.
// All segment and anode values are active-low.
package ssd_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic       ANODE_OFF = 1'b1;
    localparam logic       ANODE_ON  = 1'b0;

    // Index is the nibble value; bits are {a,b,c,d,e,f,g}.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-low abcdefg segment decoder.
// Uses the table in ssd_pkg.
import ssd_pkg::*;

module ssd_hex_decode (
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_nibble);

endmodule

// File: rtl/ssd_scan_driver.sv
// Multiplexed seven-segment scan driver with per-frame input snapshot and dead time.
// Define SSD_BLINK_EN to build the per-digit blink feature.
import ssd_pkg::*;

module ssd_scan_driver #(
    parameter int NUM_DIGITS  = 8,
    parameter int SCAN_DIV_W  = 18,
    parameter int DEAD_CYCLES = 64,
    parameter int BLINK_LOG2  = 5
) (
    input  logic                    board_clk,
    input  logic                    Reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic                    frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [SCAN_DIV_W-1:0] DEAD_END = SCAN_DIV_W'(DEAD_CYCLES);

    logic [SCAN_DIV_W-1:0]   r_div_cnt;
    logic [IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_dp;
    logic [NUM_DIGITS-1:0]   r_en;

    logic                    w_frame_start;
    logic                    w_blink_off;
    logic                    w_lit;
    logic [3:0]              w_nibble;
    logic [6:0]              w_dig_seg;
    logic [NUM_DIGITS-1:0]   w_an_next;

    assign w_frame_start = (r_div_cnt == '0) && (r_idx == '0);
    assign w_nibble      = r_digits[{r_idx, 2'b00} +: 4];

`ifdef SSD_BLINK_EN
    logic [BLINK_LOG2:0]   r_blink_cnt;
    logic [NUM_DIGITS-1:0] r_blink;

    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_blink_cnt <= '0;
            r_blink     <= '0;
        end else if (w_frame_start) begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
            r_blink     <= blink_in;
        end
    end

    assign w_blink_off = r_blink_cnt[BLINK_LOG2] & r_blink[r_idx];
`else
    wire w_unused_blink = ^{blink_in, BLINK_LOG2[0]};

    assign w_blink_off = 1'b0;
`endif

    assign w_lit = (r_div_cnt >= DEAD_END) & r_en[r_idx] & ~w_blink_off;

    ssd_hex_decode u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dig_seg)
    );

    always_comb begin
        w_an_next = {NUM_DIGITS{ANODE_OFF}};
        if (w_lit) w_an_next[r_idx] = ANODE_ON;
    end

    // Snapshot loads only at frame start so a frame never mixes old and new values.
    always_ff @(posedge board_clk or posedge Reset) begin
        if (Reset) begin
            r_div_cnt  <= '0;
            r_idx      <= '0;
            r_digits   <= '0;
            r_dp       <= '0;
            r_en       <= '0;
            an         <= {NUM_DIGITS{ANODE_OFF}};
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
            if (&r_div_cnt) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (w_frame_start) begin
                r_digits <= digits_in;
                r_dp     <= dp_in;
                r_en     <= digit_en;
            end
            frame_tick <= w_frame_start;
            an         <= w_an_next;
            seg        <= w_lit ? w_dig_seg : SEG_BLANK;
            dp         <= ~(w_lit & r_dp[r_idx]);
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver with 4 digits, 16-clock slots, 2 dead clocks.
// Expected pins are queued per clock edge and popped by a separate monitor.
module tb_ssd_scan_driver;

    localparam int ND = 4;
    localparam int SDW = 4;
    localparam int DC = 2;
    localparam int BL = 1;

    logic        board_clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  digit_en = '0;
    logic [3:0]  blink_in = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_tick;

    ssd_scan_driver #(
        .NUM_DIGITS  (ND),
        .SCAN_DIV_W  (SDW),
        .DEAD_CYCLES (DC),
        .BLINK_LOG2  (BL)
    ) dut (
        .board_clk  (board_clk),
        .Reset      (Reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .digit_en   (digit_en),
        .blink_in   (blink_in),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_tick (frame_tick)
    );

    always #5 board_clk = ~board_clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int prints = 0;
    int kcnt = 0;

    logic [15:0] s_dig = '0;
    logic [3:0]  s_dp = '0;
    logic [3:0]  s_en = '0;
    logic [3:0]  s_blk = '0;
    logic [1:0]  bcnt = '0;

    logic [6:0] tbl [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    always @(posedge Reset) begin
        kcnt  = 0;
        s_dig = '0;
        s_dp  = '0;
        s_en  = '0;
        s_blk = '0;
        bcnt  = '0;
        q.delete();
    end

    // Edge k after release shows the state of slot (k/16)%4 at offset k%16.
    always @(posedge board_clk) begin
        int   d;
        int   i;
        logic lit;
        exp_t e;
        if (!Reset) begin
            d   = kcnt % 16;
            i   = (kcnt / 16) % 4;
            lit = (d >= DC) && s_en[i];
`ifdef SSD_BLINK_EN
            if (bcnt[1] && s_blk[i]) lit = 1'b0;
`endif
            e.an   = 4'hF;
            if (lit) e.an[i] = 1'b0;
            e.seg  = lit ? tbl[s_dig[4*i +: 4]] : 7'h7F;
            e.dp   = lit ? ~s_dp[i] : 1'b1;
            e.tick = (kcnt % 64 == 0);
            q.push_back(e);
            if (kcnt % 64 == 0) begin
                s_dig = digits_in;
                s_dp  = dp_in;
                s_en  = digit_en;
                s_blk = blink_in;
                bcnt  = bcnt + 2'd1;
            end
            kcnt = kcnt + 1;
        end
    end

    always @(negedge board_clk) begin
        exp_t e;
        if (!Reset && q.size() > 0) begin
            e = q.pop_front();
            checks = checks + 1;
            if ({an, seg, dp, frame_tick} !== e) begin
                failures = failures + 1;
                if (prints < 40) begin
                    prints = prints + 1;
                    $display("FAIL scan k=%0d got an=%b seg=%b dp=%b tick=%b want an=%b seg=%b dp=%b tick=%b",
                             kcnt - 1, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
                end
            end
        end
    end

    task automatic check_reset(input string name);
        checks = checks + 1;
        if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
            failures = failures + 1;
            $display("FAIL %s got an=%b seg=%b dp=%b tick=%b want an=1111 seg=1111111 dp=1 tick=0",
                     name, an, seg, dp, frame_tick);
        end
    endtask

    task automatic wait_pos(input int m);
        for (int n = 0; n < 200; n++) begin
            @(negedge board_clk);
            if (kcnt % 64 == m) return;
        end
        checks = checks + 1;
        failures = failures + 1;
        $display("FAIL wait_pos timeout got=%0d want=%0d", kcnt % 64, m);
    endtask

    task automatic run(input int n);
        repeat (n) @(negedge board_clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout reached");
        $fatal(1);
    end

    initial begin
        digits_in = 16'h3210;
        digit_en  = 4'hF;
        #12;
        check_reset("reset_state");
        @(negedge board_clk);
        Reset = 1'b0;
        run(140);

        wait_pos(5);
        digits_in = 16'hA5C7;
        run(140);

        wait_pos(10);
        digit_en  = 4'b0101;
        dp_in     = 4'b0001;
        digits_in = 16'h8E4B;
        run(140);

        digit_en = 4'hF;
        run(70);
        wait_pos(40);
        #2 Reset = 1'b1;
        #1 check_reset("async_reset_mid_slot");
        run(3);
        check_reset("held_reset");
        Reset = 1'b0;
        run(140);

        dp_in = 4'b0000;
        digit_en = 4'b0001;
        for (int v = 0; v < 16; v++) begin
            wait_pos(10);
            digits_in = {12'h000, 4'(v)};
        end
        run(70);

`ifdef SSD_BLINK_EN
        digit_en  = 4'hF;
        digits_in = 16'h1234;
        blink_in  = 4'b0010;
        run(64 * 9);
`endif
        run(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ssd_scan_driver.md
# ssd_scan_driver

Parametrised multiplexed seven-segment display driver: time-multiplexes NUM_DIGITS hex digits, each with a decimal point and an enable, onto shared active-low cathodes and per-digit active-low anodes. Inputs are snapshotted once per frame, so a display never shows a half-updated value. Dead-time blanking at each digit switch suppresses ghosting. It replaces hand-written two-digit scan logic in the board top level.

## Interface
- NUM_DIGITS, 8: number of multiplexed digits, 2..16.
- SCAN_DIV_W, 18: prescaler width; each digit slot lasts 2^SCAN_DIV_W clocks.
- DEAD_CYCLES, 64: clocks at the start of each slot with all anodes off; 1 ≤ DEAD_CYCLES < 2^SCAN_DIV_W.
- BLINK_LOG2, 5: blink half-period is 2^BLINK_LOG2 frames (used only with SSD_BLINK_EN).
- board_clk  in  1  system clock, 100 MHz.
- Reset  in  1  asynchronous, active-high.
- digits_in  in  4*NUM_DIGITS  hex nibble per digit; digit i is [4i+3:4i].
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- digit_en  in  NUM_DIGITS  1 = digit shown, 0 = anode held off.
- blink_in  in  NUM_DIGITS  1 = digit blinks; ignored without SSD_BLINK_EN.
- an  out  NUM_DIGITS  anodes, active-low.
- seg  out  7  cathodes {Ca,Cb,Cc,Cd,Ce,Cf,Cg}, active-low; seg[6] = Ca.
- dp  out  1  decimal-point cathode, active-low.
- frame_tick  out  1  one-clock pulse per frame.

## Operation
- Reset is asynchronous, active-high; clock is board_clk.
- State: div_cnt (SCAN_DIV_W bits), idx (0..NUM_DIGITS-1), snapshot regs for digits/dp/en/blink.
- div_cnt increments every clock and wraps at 2^SCAN_DIV_W-1 → 0. On wrap, idx advances, wrapping from NUM_DIGITS-1 to 0.
- Frame start is the cycle with div_cnt==0 && idx==0. In that cycle the snapshot loads all of digits_in, dp_in, digit_en and blink_in, and frame_tick is registered high, so it is visible for exactly the next cycle.
- Input changes at any other time have no visible effect until the next frame start.
- Anodes: an[idx]=0 only when all of these hold: div_cnt ≥ DEAD_CYCLES, snapshot en[idx]=1, and the digit is not in its blink-off phase. All other anodes are 1.
- During dead time or when the digit is disabled: an all ones, seg=7'h7F, dp=1.
- Otherwise seg = hex decode of snapshot nibble idx, and dp = ~snapshot dp[idx].
- Decode, active-low abcdefg:
  - 0 0000001, 1 1001111, 2 0010010, 3 0000110, 4 1001100, 5 0100100, 6 0100000, 7 0001111
  - 8 0000000, 9 0000100, A 0001000, b 1100000, C 0110001, d 1000010, E 0110000, F 0111000
- At most one anode is low in any cycle.

## Timing
- All outputs are registered: one clock of latency from (div_cnt, idx, snapshot) to the pins.
- Reset values: an all ones, seg 7'h7F, dp 1, frame_tick 0, div_cnt 0, idx 0, snapshot all zeros (all digits disabled), blink counter 0.
- The first cycle after reset deassertion is a frame start.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronously). The scan restarts at digit 0.
- Frame period = NUM_DIGITS·2^SCAN_DIV_W clocks. With defaults: 2.62 ms per slot, 20.97 ms per frame.
- A digit's lit window is 2^SCAN_DIV_W − DEAD_CYCLES clocks, starting DEAD_CYCLES+1 clocks after its slot start (the +1 is the output register).

## Configuration
- Macro: SSD_BLINK_EN.
- Defined:
  - A BLINK_LOG2+1-bit frame counter increments at each frame start.
  - While its MSB is 1, digits with snapshot blink=1 are blanked exactly as if disabled.
  - A digit's blink phase changes only at frame boundaries.
- Undefined: no counter is built; blink_in is unconnected internally; digits never blink.

## Structure
- Package ssd_pkg contains:
  - the SEG_BLANK constant (7'h7F);
  - the 16-entry hex-to-segment function/constant array;
  - the ANODE_OFF convention.
- Sub-module ssd_hex_decode is purely combinational: 4-bit nibble in, 7-bit active-low segments out, using the ssd_pkg table.
- The prescaler, index, snapshot, blink counter and output registers stay in ssd_scan_driver.

## Test plan
Bench parameters unless stated otherwise: NUM_DIGITS=4, SCAN_DIV_W=4, DEAD_CYCLES=2.
- Reset, then digits_in=16'h3210 and digit_en=4'hF → slots cycle an=1110,1101,1011,0111 with seg 0000001,1001111,0010010,0000110. Each digit is lit for 14 clocks after 2 blank clocks. frame_tick pulses every 64 clocks.
- digits_in changed 5 clocks after a frame start → the old values stay displayed until the next frame_tick; the new values then appear starting at digit 0.
- digit_en=4'b0101 and dp_in=4'b0001 → only an[0] and an[2] ever go low; dp=0 only while an[0]=0; slots 1 and 3 show seg=7F.
- Reset pulsed mid-slot on digit 2 → an=F, seg=7F and dp=1 in the same cycle. After release, digit 0 is the first digit to light.
- All 16 nibble values on digit 0 → seg matches the decode list, including A=0001000 and F=0111000.
- SSD_BLINK_EN with BLINK_LOG2=1 and blink_in=4'b0010 → digit 1 is lit for 2 frames, then dark for 2 frames, repeating; the other digits are unaffected.
